// File: rtl/imem_loader_if.sv
// Byte-stream loader handshake shared between a program source and imem_loader.
// The source drives valid/data/last; the loader answers with ready.
interface imem_loader_if;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_last;
    logic       load_ready;

    // Program source side
    modport master (
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    // Loader side
    modport slave (
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: receives a program as a little-endian byte stream, packs it into
// 32-bit words in a small instruction memory and then releases the core from
// reset. The core fetches combinationally; anything not yet loaded reads as NOP.
//
// Optional build macro IMEM_BOUNDS_CHECK_EN: when defined, fetches beyond the
// memory window return NOP and raise a sticky fetch_fault. When undefined the
// fetch address simply wraps modulo DEPTH*4 and fetch_fault stays low.
//
// DEPTH must be a power of two and at least 4.
module imem_loader #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    imem_loader_if.slave             load,
    input  logic [31:0]              imem_addr,
    output logic [31:0]              imem_data,
    output logic                     core_reset,
    output logic                     loaded,
    output logic [$clog2(DEPTH):0]   word_count,
    output logic                     fetch_fault
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [31:0]     NOP      = 32'h0000_0013;
    localparam logic [AW:0]     WC_ONE   = (AW+1)'(1);
    localparam logic [AW:0]     WC_LAST  = (AW+1)'(DEPTH - 1);

    localparam logic [0:0]      ST_LOAD  = 1'b0;
    localparam logic [0:0]      ST_RUN   = 1'b1;

    // Control and datapath state
    logic [0:0]   state_reg, state_next;
    logic [1:0]   byte_cnt_reg, byte_cnt_next;
    logic [31:0]  asm_reg, asm_next;
    logic [AW:0]  word_count_reg, word_count_next;
    logic         loaded_reg;
    logic         core_reset_reg;
    logic         fault_reg, fault_next;

    // Instruction storage; read asynchronously so the core sees the word in
    // the same cycle it presents the address.
    logic [31:0]  mem [DEPTH];

    logic         accept;
    logic         write_en;
    logic [3:0]   below_mask;
    logic [31:0]  word_assembled;
    logic [AW-1:0] rd_idx;
    logic         out_of_range;
    logic         rd_hit;
    logic [1:0]   unused_addr_bits;

    // Handshake: ready is a pure function of the state register.
    assign load.load_ready = (state_reg == ST_LOAD);
    assign accept          = load.load_valid && load.load_ready;

    // A word is committed when its fourth byte arrives, or early when the
    // final program byte lands part-way through a word.
    assign write_en = accept && ((byte_cnt_reg == 2'd3) || load.load_last);

    // Lanes below the byte cursor keep what was already assembled; the lane at
    // the cursor takes the incoming byte; lanes above read as zero, which is
    // exactly the zero-fill needed when the program ends mid-word.
    assign below_mask = (4'b0001 << byte_cnt_reg) - 4'd1;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign word_assembled[8*gi +: 8] =
                below_mask[gi]         ? asm_reg[8*gi +: 8] :
                (byte_cnt_reg == LANE) ? load.load_data     :
                                         8'h00;
        end
    endgenerate

    // Next-state logic for the loader: byte cursor, assembly word, word count
    // and the one-way LOAD -> RUN transition.
    always_comb begin
        state_next      = state_reg;
        byte_cnt_next   = byte_cnt_reg;
        asm_next        = asm_reg;
        word_count_next = word_count_reg;
        if (accept) begin
            asm_next      = word_assembled;
            byte_cnt_next = byte_cnt_reg + 2'd1;
            if (write_en) begin
                byte_cnt_next   = 2'd0;
                word_count_next = word_count_reg + WC_ONE;
                // Either the program says it is done, or the memory is full.
                if (load.load_last || (word_count_reg == WC_LAST)) begin
                    state_next = ST_RUN;
                end
            end
        end
    end

    // Fetch-side address decode. The low two address bits never select a word.
    assign rd_idx = imem_addr[AW+1:2];

`ifdef IMEM_BOUNDS_CHECK_EN
    // Any set bit above the memory window means the fetch is out of range.
    assign out_of_range     = (imem_addr[31:AW+2] != '0);
    assign fault_next       = fault_reg || ((state_reg == ST_RUN) && out_of_range);
    assign unused_addr_bits = imem_addr[1:0];
`else
    // Upper address bits are discarded, so fetches wrap around the memory.
    assign out_of_range     = 1'b0;
    assign fault_next       = 1'b0;
    assign unused_addr_bits = {^imem_addr[31:AW+2], ^imem_addr[1:0]};
`endif

    // Only words actually written since the last reset are visible, and only
    // once the core is running; everything else reads as NOP. This is what
    // hides stale contents left in the array across a reset.
    assign rd_hit    = (state_reg == ST_RUN) && !out_of_range &&
                       ({1'b0, rd_idx} < word_count_reg);
    assign imem_data = rd_hit ? mem[rd_idx] : NOP;

    // Control registers, including the registered core-facing status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_LOAD;
            byte_cnt_reg   <= 2'd0;
            asm_reg        <= 32'h0;
            word_count_reg <= '0;
            loaded_reg     <= 1'b0;
            core_reset_reg <= 1'b1;
            fault_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            byte_cnt_reg   <= byte_cnt_next;
            asm_reg        <= asm_next;
            word_count_reg <= word_count_next;
            loaded_reg     <= (state_next == ST_RUN);
            core_reset_reg <= (state_next != ST_RUN);
            fault_reg      <= fault_next;
        end
    end

    // Memory write port; contents are deliberately not cleared by reset, and a
    // word completing in a reset cycle is dropped.
    always_ff @(posedge clk) begin
        if (write_en && !reset) begin
            mem[word_count_reg[AW-1:0]] <= word_assembled;
        end
    end

    assign loaded      = loaded_reg;
    assign core_reset  = core_reset_reg;
    assign word_count  = word_count_reg;
    assign fetch_fault = fault_reg;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: two instances (DEPTH=64 and DEPTH=4) driven one at
// a time. Every cycle is checked against a byte-queue reference model; directed
// tables and sequences cover the documented corner cases.
module tb_imem_loader;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr0 = '0, addr1 = '0;
    logic [31:0] data0, data1;
    logic        cr0, cr1, ldd0, ldd1, ff0, ff1;
    logic [6:0]  wc0;
    logic [2:0]  wc1;

    imem_loader_if ld0 ();
    imem_loader_if ld1 ();

    imem_loader #(.DEPTH(64)) dut (
        .clk(clk), .reset(rst), .load(ld0),
        .imem_addr(addr0), .imem_data(data0), .core_reset(cr0),
        .loaded(ldd0), .word_count(wc0), .fetch_fault(ff0)
    );

    imem_loader #(.DEPTH(4)) dut4 (
        .clk(clk), .reset(rst), .load(ld1),
        .imem_addr(addr1), .imem_data(data1), .core_reset(cr1),
        .loaded(ldd1), .word_count(wc1), .fetch_fault(ff1)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int sel   = 0;

    // Reference model: accepted bytes in order, run flag, sticky fault
    logic [7:0] q[$];
    bit         m_run   = 1'b0;
    bit         m_fault = 1'b0;

    // Observed outputs of the selected instance, captured mid-cycle
    logic [31:0] obs_data, obs_wc;
    logic        obs_ready, obs_loaded, obs_cr, obs_fault;

    function automatic int mdepth();
        return (sel == 1) ? 4 : 64;
    endfunction

    function automatic bit bounds_on();
`ifdef IMEM_BOUNDS_CHECK_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic int exp_wc();
        return m_run ? (q.size() + 3) / 4 : q.size() / 4;
    endfunction

    function automatic logic [31:0] exp_data(input logic [31:0] a);
        int unsigned idx;
        logic [31:0] w;
        if (!m_run) return NOP;
        if (bounds_on() && (a >= 32'(4 * mdepth()))) return NOP;
        idx = (a >> 2) % mdepth();
        if (idx >= exp_wc()) return NOP;
        w = '0;
        for (int i = 0; i < 4; i++)
            if (4 * idx + i < q.size()) w = w | (32'(q[4*idx+i]) << (8 * i));
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h (sel=%0d t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d, input bit l, input logic [31:0] a);
        if (bounds_on() && m_run && (a >= 32'(4 * mdepth()))) m_fault = 1'b1;
        if (!m_run && v) begin
            q.push_back(d);
            if (l || (q.size() == 4 * mdepth())) m_run = 1'b1;
        end
    endtask

    // One clock of stimulus on the selected instance, fully checked vs model
    task automatic cyc(input bit v, input logic [7:0] d, input bit l, input logic [31:0] a);
        logic [31:0] ed;
        @(negedge clk);
        rst = 1'b0;
        if (sel == 0) begin
            ld0.load_valid = v; ld0.load_data = d; ld0.load_last = l; addr0 = a;
            ld1.load_valid = 1'b0;
        end else begin
            ld1.load_valid = v; ld1.load_data = d; ld1.load_last = l; addr1 = a;
            ld0.load_valid = 1'b0;
        end
        #1;
        obs_data   = (sel == 1) ? data1 : data0;
        obs_wc     = (sel == 1) ? 32'(wc1) : 32'(wc0);
        obs_ready  = (sel == 1) ? ld1.load_ready : ld0.load_ready;
        obs_loaded = (sel == 1) ? ldd1 : ldd0;
        obs_cr     = (sel == 1) ? cr1 : cr0;
        obs_fault  = (sel == 1) ? ff1 : ff0;
        ed = exp_data(a);
        chk("ready",      32'(obs_ready),  32'(!m_run));
        chk("loaded",     32'(obs_loaded), 32'(m_run));
        chk("core_reset", 32'(obs_cr),     32'(!m_run));
        chk("word_count", obs_wc,          32'(exp_wc()));
        chk("imem_data",  obs_data,        ed);
        chk("fetch_fault", 32'(obs_fault), 32'(m_fault));
        $display("cyc sel=%0d v=%0d d=%02h l=%0d a=%08h data=%08h wc=%0d rdy=%0d",
                 sel, v, d, l, a, obs_data, obs_wc, obs_ready);
        @(posedge clk);
        model_edge(v, d, l, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        ld0.load_valid = 1'b0;
        ld1.load_valid = 1'b0;
        @(posedge clk);
        q.delete();
        m_run   = 1'b0;
        m_fault = 1'b0;
    endtask

    function automatic logic [31:0] raddr();
        if ($urandom_range(0, 4) == 0) return $urandom;
        return 32'($urandom_range(0, 8 * mdepth() - 1));
    endfunction

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         l;
        bit         exp_ready;
        int         exp_wc;
    } vec_t;

    vec_t tbl[9];

    initial begin
        ld0.load_valid = 1'b0; ld0.load_data = '0; ld0.load_last = 1'b0;
        ld1.load_valid = 1'b0; ld1.load_data = '0; ld1.load_last = 1'b0;

        // Two-word program, back to back, last on the final byte
        tbl[0] = '{1'b1, 8'h13, 1'b0, 1'b1, 0};
        tbl[1] = '{1'b1, 8'h05, 1'b0, 1'b1, 0};
        tbl[2] = '{1'b1, 8'h00, 1'b0, 1'b1, 0};
        tbl[3] = '{1'b1, 8'h00, 1'b0, 1'b1, 0};
        tbl[4] = '{1'b1, 8'h93, 1'b0, 1'b1, 1};
        tbl[5] = '{1'b1, 8'h00, 1'b0, 1'b1, 1};
        tbl[6] = '{1'b1, 8'h10, 1'b0, 1'b1, 1};
        tbl[7] = '{1'b1, 8'h00, 1'b1, 1'b1, 1};
        tbl[8] = '{1'b0, 8'h55, 1'b0, 1'b0, 2};

        sel = 0;
        do_reset();
        for (int i = 0; i < 9; i++) begin
            cyc(tbl[i].v, tbl[i].d, tbl[i].l, 32'h0);
            chk("tbl_ready", 32'(obs_ready), 32'(tbl[i].exp_ready));
            chk("tbl_wc",    obs_wc,         32'(tbl[i].exp_wc));
        end
        chk("prog_loaded", 32'(obs_loaded), 32'd1);
        chk("prog_corerst", 32'(obs_cr), 32'd0);
        cyc(1'b0, 8'h0, 1'b0, 32'h0); chk("prog_w0", obs_data, 32'h0000_0513);
        cyc(1'b0, 8'h0, 1'b0, 32'h4); chk("prog_w1", obs_data, 32'h0010_0093);
        cyc(1'b0, 8'h0, 1'b0, 32'h7); chk("prog_w1_lowbits", obs_data, 32'h0010_0093);
        cyc(1'b0, 8'h0, 1'b0, 32'h8); chk("prog_past_end", obs_data, NOP);
        cyc(1'b1, 8'hEE, 1'b1, 32'h0); // dropped in RUN
        cyc(1'b0, 8'h0, 1'b0, 32'h0); chk("run_no_accept_wc", obs_wc, 32'd2);

        // Out-of-window fetch in RUN
        cyc(1'b0, 8'h0, 1'b0, 32'h100);
        chk("oob_data", obs_data, bounds_on() ? NOP : 32'h0000_0513);
        cyc(1'b0, 8'h0, 1'b0, 32'h0);
        chk("oob_fault", 32'(obs_fault), 32'(bounds_on()));

        // Two-byte program ending mid-word
        do_reset();
        cyc(1'b0, 8'h0, 1'b0, 32'h0);
        chk("rst_fault_clear", 32'(obs_fault), 32'd0);
        chk("rst_wc", obs_wc, 32'd0);
        cyc(1'b1, 8'hB7, 1'b0, 32'h0);
        cyc(1'b1, 8'h10, 1'b1, 32'h0);
        chk("short_data", obs_data, NOP);
        cyc(1'b0, 8'h0, 1'b0, 32'h0);
        chk("short_w0", obs_data, 32'h0000_10B7);
        chk("short_wc", obs_wc, 32'd1);
        chk("short_loaded", 32'(obs_loaded), 32'd1);
        cyc(1'b0, 8'h0, 1'b0, 32'h4);
        chk("short_w1_nop", obs_data, NOP);

        // Valid toggling; idle cycles carry junk data and a stray last
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 8'(8'h21 + i), (i == 7), 32'h0);
            cyc(1'b0, 8'hFF, 1'b1, 32'h0);
        end
        chk("toggle_wc", obs_wc, 32'd2);
        cyc(1'b0, 8'h0, 1'b0, 32'h0); chk("toggle_w0", obs_data, 32'h2423_2221);
        cyc(1'b0, 8'h0, 1'b0, 32'h4); chk("toggle_w1", obs_data, 32'h2827_2625);

        // Reset in the middle of a word, then a fresh one-word program
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 32'h0);
        do_reset();
        cyc(1'b0, 8'h0, 1'b0, 32'h4);
        chk("midrst_wc", obs_wc, 32'd0);
        chk("midrst_loaded", 32'(obs_loaded), 32'd0);
        chk("midrst_corerst", 32'(obs_cr), 32'd1);
        cyc(1'b1, 8'hAA, 1'b0, 32'h0);
        cyc(1'b1, 8'hBB, 1'b0, 32'h0);
        cyc(1'b1, 8'hCC, 1'b0, 32'h0);
        cyc(1'b1, 8'hDD, 1'b1, 32'h0);
        cyc(1'b0, 8'h0, 1'b0, 32'h0); chk("reload_w0", obs_data, 32'hDDCC_BBAA);
        cyc(1'b0, 8'h0, 1'b0, 32'h4); chk("reload_stale_nop", obs_data, NOP);

        // Overflow on the small instance: 20 bytes, no last
        sel = 1;
        do_reset();
        for (int i = 0; i < 20; i++) cyc(1'b1, 8'(i + 1), 1'b0, 32'h0);
        chk("ovf_wc", obs_wc, 32'd4);
        chk("ovf_ready", 32'(obs_ready), 32'd0);
        cyc(1'b0, 8'h0, 1'b0, 32'hC);  chk("ovf_w3", obs_data, 32'h100F_0E0D);
        cyc(1'b0, 8'h0, 1'b0, 32'h10);
        chk("ovf_wrap", obs_data, bounds_on() ? NOP : 32'h0403_0201);

        // Randomized programs on both instances
        for (int r = 0; r < 14; r++) begin
            int  n;
            bit  use_last;
            sel = r % 2;
            do_reset();
            n = (sel == 1) ? $urandom_range(1, 22) : $urandom_range(1, 70);
            use_last = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < n; i++) begin
                while ($urandom_range(0, 2) == 0)
                    cyc(1'b0, 8'($urandom), 1'($urandom_range(0, 1)), raddr());
                cyc(1'b1, 8'($urandom), use_last && (i == n - 1), raddr());
            end
            repeat (12) cyc(1'b0, 8'($urandom), 1'b0, raddr());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete (bad=%0d)", bad);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 64, meaning instruction words stored (power of two, >=4).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port load_valid  input  1  loader byte present.
REQ-005 SHALL have port load_data  input  8  program byte, little-endian order within each word.
REQ-006 SHALL have port load_last  input  1  qualifies final byte of program.
REQ-007 SHALL have port load_ready  output  1  block accepts a byte this cycle.
REQ-008 SHALL have port imem_addr  input  32  core fetch byte address.
REQ-009 SHALL have port imem_data  output  32  instruction word for imem_addr.
REQ-010 SHALL have port core_reset  output  1  holds core in reset until program loaded.
REQ-011 SHALL have port loaded  output  1  program load complete.
REQ-012 SHALL have port word_count  output  clog2(DEPTH)+1  words written so far.
REQ-013 SHALL have port fetch_fault  output  1  sticky out-of-range fetch flag.

Function
REQ-014 SHALL implement two states, LOAD and RUN; reset enters LOAD.
REQ-015 SHALL drive load_ready=1 in LOAD and load_ready=0 in RUN.
REQ-016 SHALL accept a byte on cycles where load_valid and load_ready are both 1.
REQ-017 SHALL place accepted byte k (k=0..3, per-word byte counter) in bits [8k+7:8k] of the assembly register.
REQ-018 SHALL write the assembled word to mem[word_count] and increment word_count on acceptance of byte 3; the byte counter SHALL wrap to 0.
REQ-019 SHALL, when load_last is accepted mid-word, zero-fill the remaining upper bytes and write the word in that same cycle.
REQ-020 SHALL transition LOAD->RUN on the cycle after load_last is accepted, or after the write that makes word_count equal DEPTH (overflow); further bytes SHALL NOT be accepted.
REQ-021 SHALL ignore load_last when load_valid is 0.
REQ-022 SHALL drive loaded=1 and core_reset=0 exactly when the state is RUN, both registered with no combinational path from load inputs.
REQ-023 SHALL drive imem_data combinationally from word index imem_addr[clog2(DEPTH)+1:2]; imem_addr[1:0] SHALL be ignored.
REQ-024 SHALL return NOP 0x00000013 for any index >= word_count, and for every address while in LOAD.
REQ-025 SHALL remain in RUN until reset; RUN has no exit other than reset.

Reset
REQ-026 SHALL on reset set state=LOAD, byte counter=0, word_count=0, assembly register=0, loaded=0, core_reset=1, load_ready=1 (first cycle after reset), fetch_fault=0.
REQ-027 SHALL NOT clear memory array contents on reset; stale words SHALL be masked by REQ-024.
REQ-028 SHALL abandon a partially assembled word on reset mid-load without writing it.

Configuration
REQ-029 SHALL, with IMEM_BOUNDS_CHECK_EN defined, return NOP for imem_addr >= DEPTH*4 in RUN and set fetch_fault on the next edge, holding it until reset.
REQ-030 SHALL, without IMEM_BOUNDS_CHECK_EN, wrap imem_addr modulo DEPTH*4 and tie fetch_fault to 0.

Verification
REQ-031 SHALL cover: bytes 13,05,00,00 then 93,00,10,00 (last on final byte) -> word_count=2, mem[0]=0x00000513, mem[1]=0x00100093, loaded=1 and core_reset=0 the following cycle.
REQ-032 SHALL cover: bytes B7,10 with load_last on 10 -> mem[0]=0x000010B7, word_count=1, RUN next cycle; imem_addr=4 -> 0x00000013.
REQ-033 SHALL cover: load_valid toggled 1/0 every cycle across 8 bytes -> identical memory contents to back-to-back load; no byte accepted while load_valid=0.
REQ-034 SHALL cover: DEPTH=4, 20 bytes offered, none with last -> RUN after 16th byte, load_ready=0 from then, bytes 17-20 dropped, word_count=4.
REQ-035 SHALL cover: reset asserted after 6 of 8 bytes -> word_count=0, loaded=0, core_reset=1; reload of 4 bytes ending with last -> mem[0] holds new word, imem_addr=4 returns 0x00000013.
REQ-036 SHALL cover: DEPTH=64, RUN, imem_addr=0x100 -> NOP and fetch_fault=1 next cycle with IMEM_BOUNDS_CHECK_EN; mem[0] and fetch_fault=0 without it.
